// File: rtl/pe_vec_typed.sv
// LANES-wide signed fixed-point processing element with a reduction FSM and a
// delay-matched bypass. Every path to out1 is exactly LAT register stages deep.
module pe_vec_typed #(
  parameter int LANES  = 4,
  parameter int DWIDTH = 32,
  parameter int FRAC   = 16,
  parameter int LAT    = 4,
  parameter int LENW   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LANES*DWIDTH-1:0] inp1,
  input  logic [LANES*DWIDTH-1:0] inp2,
  input  logic                    t_valid_inp1,
  input  logic                    t_valid_inp2,
  input  logic [2:0]              op,
  input  logic [LENW-1:0]         acc_len,
  input  logic                    flush,
  output logic [LANES*DWIDTH-1:0] out1,
  output logic                    t_valid_out1,
  output logic [LANES*DWIDTH-1:0] out2,
  output logic                    t_valid_out2,
  output logic                    busy,
  output logic [15:0]             drop_cnt
);

  localparam int W = LANES * DWIDTH;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_ACC  = 3'b001,
    OP_MUL  = 3'b010,
    OP_MACC = 3'b011,
    OP_NOP  = 3'b100,
    OP_SUB  = 3'b101,
    OP_PASS = 3'b110,
    OP_NOP2 = 3'b111
  } op_e;

  typedef enum logic {S_IDLE, S_ACCUM} state_e;

  function automatic logic signed [DWIDTH-1:0] fx_mul(input logic signed [DWIDTH-1:0] a,
                                                       input logic signed [DWIDTH-1:0] b);
    logic signed [2*DWIDTH-1:0] ax, bx;
    ax = {{DWIDTH{a[DWIDTH-1]}}, a};
    bx = {{DWIDTH{b[DWIDTH-1]}}, b};
    return DWIDTH'((ax * bx) >>> FRAC);
  endfunction

  function automatic logic signed [DWIDTH-1:0] lane_alu(input op_e o,
                                                         input logic signed [DWIDTH-1:0] a,
                                                         input logic signed [DWIDTH-1:0] b);
    case (o)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_MUL:  return fx_mul(a, b);
      default: return a;
    endcase
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] c, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, c} + {15'b0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  op_e              op_p0;
  logic             bin_p0, un_p0, fire_p0, drop_p0, acc_op_p0;
  logic [W-1:0]     alu_p0, elem_p0, acc_sum_p0;

  state_e           state_q, state_n;
  op_e              lop_q, lop_n;
  logic [W-1:0]     sum_q, sum_n, acc_out;
  logic [LENW-1:0]  cnt_q, cnt_n, len_q, len_n, eff_len;
  logic             acc_emit, abort;
  logic [1:0]       drop_inc;

  logic [W-1:0]     res_p0;
  logic             vld_p0;
  logic [W-1:0]     res_pn [LAT];
  logic [LAT-1:0]   vld_pn;
  logic [W-1:0]     byp_pn [LAT];
  logic [LAT-1:0]   bvld_pn;

  // Stage 0: fire decode, lane arithmetic and reduction next-state.
  assign op_p0     = op_e'(op);
  assign bin_p0    = (op_p0 == OP_ADD) || (op_p0 == OP_SUB) || (op_p0 == OP_MUL) || (op_p0 == OP_MACC);
  assign un_p0     = (op_p0 == OP_ACC) || (op_p0 == OP_PASS);
  assign acc_op_p0 = (op_p0 == OP_ACC) || (op_p0 == OP_MACC);
  assign fire_p0   = bin_p0 ? (t_valid_inp1 && t_valid_inp2) : (un_p0 && t_valid_inp1);
  assign drop_p0   = bin_p0 && (t_valid_inp1 ^ t_valid_inp2);

  always_comb begin
    alu_p0     = '0;
    elem_p0    = '0;
    acc_sum_p0 = '0;
    for (int i = 0; i < LANES; i++) begin
      alu_p0[i*DWIDTH +: DWIDTH]  = lane_alu(op_p0, inp1[i*DWIDTH +: DWIDTH], inp2[i*DWIDTH +: DWIDTH]);
      elem_p0[i*DWIDTH +: DWIDTH] = (op_p0 == OP_MACC) ?
                                    fx_mul(inp1[i*DWIDTH +: DWIDTH], inp2[i*DWIDTH +: DWIDTH]) :
                                    inp1[i*DWIDTH +: DWIDTH];
      acc_sum_p0[i*DWIDTH +: DWIDTH] = sum_q[i*DWIDTH +: DWIDTH] + elem_p0[i*DWIDTH +: DWIDTH];
    end
  end

  // An op change during ACCUM aborts the run; the same cycle then behaves as an IDLE cycle.
  always_comb begin
    state_n  = state_q;
    lop_n    = lop_q;
    sum_n    = sum_q;
    cnt_n    = cnt_q;
    len_n    = len_q;
    acc_emit = 1'b0;
    acc_out  = sum_q;
    abort    = 1'b0;
    eff_len  = (acc_len == '0) ? LENW'(1) : acc_len;
    if (state_q == S_ACCUM && op_p0 != lop_q) begin
      abort   = 1'b1;
      state_n = S_IDLE;
      sum_n   = '0;
      cnt_n   = '0;
    end
    if (state_q == S_IDLE || abort) begin
      if (fire_p0 && acc_op_p0) begin
        lop_n = op_p0;
        cnt_n = LENW'(1);
        len_n = eff_len;
        if (eff_len == LENW'(1)) begin
          acc_emit = 1'b1;
          acc_out  = elem_p0;
          sum_n    = '0;
          state_n  = S_IDLE;
        end else begin
          sum_n   = elem_p0;
          state_n = S_ACCUM;
        end
      end
    end else if (fire_p0) begin
      cnt_n = cnt_q + LENW'(1);
      if (cnt_n == len_q || flush) begin
        acc_emit = 1'b1;
        acc_out  = acc_sum_p0;
        sum_n    = '0;
        cnt_n    = '0;
        state_n  = S_IDLE;
      end else begin
        sum_n = acc_sum_p0;
      end
    end else if (flush) begin
      acc_emit = 1'b1;
      acc_out  = sum_q;
      sum_n    = '0;
      cnt_n    = '0;
      state_n  = S_IDLE;
    end
  end

  assign res_p0   = acc_emit ? acc_out : alu_p0;
  assign vld_p0   = acc_emit || (fire_p0 && !acc_op_p0);
  assign drop_inc = {1'b0, drop_p0} + {1'b0, abort};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      lop_q    <= OP_ACC;
      sum_q    <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      drop_cnt <= '0;
    end else begin
      state_q  <= state_n;
      lop_q    <= lop_n;
      sum_q    <= sum_n;
      cnt_q    <= cnt_n;
      len_q    <= len_n;
      drop_cnt <= sat_add16(drop_cnt, drop_inc);
    end
  end

  // Stages 1..LAT: result and bypass delay lines of equal depth.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) begin
        res_pn[i] <= '0;
        byp_pn[i] <= '0;
      end
      vld_pn  <= '0;
      bvld_pn <= '0;
    end else begin
      res_pn[0] <= res_p0;
      byp_pn[0] <= inp1;
      for (int i = 1; i < LAT; i++) begin
        res_pn[i] <= res_pn[i-1];
        byp_pn[i] <= byp_pn[i-1];
      end
      vld_pn  <= {vld_pn[LAT-2:0], vld_p0};
      bvld_pn <= {bvld_pn[LAT-2:0], t_valid_inp1};
    end
  end

  assign out1         = res_pn[LAT-1];
  assign t_valid_out1 = vld_pn[LAT-1];
  assign out2         = byp_pn[LAT-1];
  assign t_valid_out2 = bvld_pn[LAT-1];
  assign busy         = (state_q == S_ACCUM);

endmodule
